// File: rtl/rv32_decode_stage.sv
// ============================================================================
// rv32_decode_stage : registered RV32I decode between fetch and execute.
// Optional M-extension decode enabled by defining RV32_DECODE_M_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rv32_decode_stage #(
  parameter int PcWidth = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [PcWidth-1:0] in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PcWidth-1:0] out_pc,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic [31:0]        out_imm,
  output logic [4:0]         out_alu_op,
  output logic               out_use_imm,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic [2:0]         out_mem_f3,
  output logic               out_branch,
  output logic [2:0]         out_br_f3,
  output logic               out_jal,
  output logic               out_jalr,
  output logic               out_lui,
  output logic               out_auipc,
  output logic               out_system,
  output logic               out_illegal
);

  localparam int RegAddrWidth = 5;

  localparam logic [6:0] OpAluR   = 7'b0110011;
  localparam logic [6:0] OpAluI   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAUIPC  = 7'b0010111;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [4:0] AluAdd  = 5'd0;
  localparam logic [4:0] AluSub  = 5'd1;
  localparam logic [4:0] AluSll  = 5'd2;
  localparam logic [4:0] AluSlt  = 5'd3;
  localparam logic [4:0] AluSltu = 5'd4;
  localparam logic [4:0] AluXor  = 5'd5;
  localparam logic [4:0] AluSrl  = 5'd6;
  localparam logic [4:0] AluSra  = 5'd7;
  localparam logic [4:0] AluOr   = 5'd8;
  localparam logic [4:0] AluAnd  = 5'd9;
`ifdef RV32_DECODE_M_EN
  localparam logic [4:0] AluMul  = 5'd10;
`endif

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
`ifdef RV32_DECODE_M_EN
  localparam logic [6:0] F7MulDiv = 7'b0000001;
`endif

  // Plain funct3 -> ALU op mapping shared by register and immediate forms.
  function automatic logic [4:0] base_alu_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [RegAddrWidth-1:0] rd_field;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [31:0] imm_d;
  logic [4:0]  alu_op_d;
  logic        use_imm_d, rw_raw, reg_write_d, mem_read_d, mem_write_d;
  logic        branch_d, jal_d, jalr_d, lui_d, auipc_d, system_d, illegal_d;

  always_comb begin
    opcode   = in_instr[6:0];
    f3       = in_instr[14:12];
    f7       = in_instr[31:25];
    rd_field = in_instr[11:7];
    imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
             in_instr[11:8], 1'b0};
    imm_u = {in_instr[31:12], 12'b0};
    imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
             in_instr[30:21], 1'b0};

    imm_d       = '0;
    alu_op_d    = AluAdd;
    use_imm_d   = 1'b0;
    rw_raw      = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    jal_d       = 1'b0;
    jalr_d      = 1'b0;
    lui_d       = 1'b0;
    auipc_d     = 1'b0;
    system_d    = 1'b0;
    illegal_d   = 1'b0;

    if (in_instr[1:0] != 2'b11) begin
      illegal_d = 1'b1;
    end else begin
      case (opcode)
        OpAluR: begin
          rw_raw = 1'b1;
          case (f7)
            F7Base: alu_op_d = base_alu_op(f3);
            F7Alt: begin
              if (f3 == 3'b000)      alu_op_d  = AluSub;
              else if (f3 == 3'b101) alu_op_d  = AluSra;
              else                   illegal_d = 1'b1;
            end
`ifdef RV32_DECODE_M_EN
            F7MulDiv: alu_op_d = AluMul + {2'b00, f3};
`endif
            default: illegal_d = 1'b1;
          endcase
        end
        OpAluI: begin
          rw_raw    = 1'b1;
          use_imm_d = 1'b1;
          imm_d     = imm_i;
          alu_op_d  = base_alu_op(f3);
          // Shift-immediates carry funct7 in imm[11:5]; ALU-I never yields SUB.
          if (f3 == 3'b001 && f7 != F7Base) illegal_d = 1'b1;
          if (f3 == 3'b101) begin
            if (f7 == F7Alt)        alu_op_d  = AluSra;
            else if (f7 != F7Base)  illegal_d = 1'b1;
          end
        end
        OpLoad: begin
          rw_raw     = 1'b1;
          mem_read_d = 1'b1;
          use_imm_d  = 1'b1;
          imm_d      = imm_i;
          if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illegal_d = 1'b1;
        end
        OpStore: begin
          mem_write_d = 1'b1;
          use_imm_d   = 1'b1;
          imm_d       = imm_s;
          if (f3 > 3'b010) illegal_d = 1'b1;
        end
        OpBranch: begin
          branch_d = 1'b1;
          imm_d    = imm_b;
          if (f3 == 3'b010 || f3 == 3'b011) illegal_d = 1'b1;
        end
        OpJal: begin
          rw_raw = 1'b1;
          jal_d  = 1'b1;
          imm_d  = imm_j;
        end
        OpJalr: begin
          rw_raw    = 1'b1;
          jalr_d    = 1'b1;
          use_imm_d = 1'b1;
          imm_d     = imm_i;
          if (f3 != 3'b000) illegal_d = 1'b1;
        end
        OpLui: begin
          rw_raw    = 1'b1;
          lui_d     = 1'b1;
          use_imm_d = 1'b1;
          imm_d     = imm_u;
        end
        OpAUIPC: begin
          rw_raw    = 1'b1;
          auipc_d   = 1'b1;
          use_imm_d = 1'b1;
          imm_d     = imm_u;
        end
        OpMisc: begin
          imm_d = imm_i;
        end
        OpSystem: begin
          imm_d = imm_i;
          if (f3 == 3'b000) begin
            if (in_instr[31:20] == 12'd0 || in_instr[31:20] == 12'd1) system_d  = 1'b1;
            else                                                       illegal_d = 1'b1;
          end else if (f3 == 3'b100) begin
            illegal_d = 1'b1;
          end else begin
            system_d = 1'b1;
            rw_raw   = 1'b1;
          end
        end
        default: illegal_d = 1'b1;
      endcase
    end

    // Illegal encodings travel downstream but must not cause side effects.
    if (illegal_d) begin
      rw_raw      = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      branch_d    = 1'b0;
      jal_d       = 1'b0;
      jalr_d      = 1'b0;
      system_d    = 1'b0;
    end
    reg_write_d = rw_raw && (rd_field != '0);
  end

  logic               valid_q;
  logic [PcWidth-1:0] pc_q;
  logic [4:0]         rs1_q, rs2_q, rd_q, alu_op_q;
  logic [31:0]        imm_q;
  logic [2:0]         f3_q;
  logic               use_imm_q, reg_write_q, mem_read_q, mem_write_q;
  logic               branch_q, jal_q, jalr_q, lui_q, auipc_q, system_q, illegal_q;

  assign in_ready = !valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_op_q    <= '0;
      f3_q        <= '0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      jal_q       <= 1'b0;
      jalr_q      <= 1'b0;
      lui_q       <= 1'b0;
      auipc_q     <= 1'b0;
      system_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q     <= 1'b1;
      pc_q        <= in_pc;
      rs1_q       <= in_instr[19:15];
      rs2_q       <= in_instr[24:20];
      rd_q        <= in_instr[11:7];
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      f3_q        <= in_instr[14:12];
      use_imm_q   <= use_imm_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
      jal_q       <= jal_d;
      jalr_q      <= jalr_d;
      lui_q       <= lui_d;
      auipc_q     <= auipc_d;
      system_q    <= system_d;
      illegal_q   <= illegal_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_rd        = rd_q;
  assign out_imm       = imm_q;
  assign out_alu_op    = alu_op_q;
  assign out_use_imm   = use_imm_q;
  assign out_reg_write = reg_write_q;
  assign out_mem_read  = mem_read_q;
  assign out_mem_write = mem_write_q;
  assign out_mem_f3    = f3_q;
  assign out_branch    = branch_q;
  assign out_br_f3     = f3_q;
  assign out_jal       = jal_q;
  assign out_jalr      = jalr_q;
  assign out_lui       = lui_q;
  assign out_auipc     = auipc_q;
  assign out_system    = system_q;
  assign out_illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32_decode_stage.sv
// ============================================================================
// tb_rv32_decode_stage : directed self-checking bench for rv32_decode_stage.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_op;
  logic [2:0]  out_mem_f3, out_br_f3;
  logic        out_use_imm, out_reg_write, out_mem_read, out_mem_write, out_branch;
  logic        out_jal, out_jalr, out_lui, out_auipc, out_system, out_illegal;
  logic [10:0] flags;

  localparam logic [10:0] F_RW = 11'h400, F_MR = 11'h200, F_MW = 11'h100, F_BR = 11'h080;
  localparam logic [10:0] F_JAL = 11'h040, F_JALR = 11'h020, F_LUI = 11'h010, F_AUIPC = 11'h008;
  localparam logic [10:0] F_SYS = 11'h004, F_ILL = 11'h002, F_IMM = 11'h001;

  int checks = 0;
  int errors = 0;
  logic [31:0] outq[$];

  rv32_decode_stage #(.PcWidth(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_use_imm(out_use_imm), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_f3(out_mem_f3),
    .out_branch(out_branch), .out_br_f3(out_br_f3), .out_jal(out_jal), .out_jalr(out_jalr),
    .out_lui(out_lui), .out_auipc(out_auipc), .out_system(out_system), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  assign flags = {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal, out_jalr,
                  out_lui, out_auipc, out_system, out_illegal, out_use_imm};

  // Log every bundle execute actually consumes.
  always @(posedge clk) if (!rst && !flush && out_valid && out_ready) outq.push_back(out_pc);

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    outq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0; in_pc = '0;
    repeat (3) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (flags !== 11'h000) begin errors++; $display("FAIL reset_flags got %h want 000", flags); end
    checks++; if (out_pc !== 32'h0 || out_imm !== 32'h0) begin errors++; $display("FAIL reset_payload got pc %h imm %h want 0", out_pc, out_imm); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    send(32'hFFF00093, 32'h100);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got %h want 100", out_pc); end
    checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin errors++; $display("FAIL addi_regs got rd %0d rs1 %0d want 1 0", out_rd, out_rs1); end
    checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
    checks++; if (out_alu_op !== 5'd0) begin errors++; $display("FAIL addi_alu got %0d want 0", out_alu_op); end
    checks++; if (flags !== (F_RW | F_IMM)) begin errors++; $display("FAIL addi_flags got %h want %h", flags, F_RW | F_IMM); end
  endtask

  task automatic test_store();
    send(32'h0020A223, 32'h104);
    checks++; if (flags !== (F_MW | F_IMM)) begin errors++; $display("FAIL sw_flags got %h want %h", flags, F_MW | F_IMM); end
    checks++; if (out_mem_f3 !== 3'b010) begin errors++; $display("FAIL sw_f3 got %b want 010", out_mem_f3); end
    checks++; if (out_imm !== 32'd4) begin errors++; $display("FAIL sw_imm got %h want 4", out_imm); end
    checks++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin errors++; $display("FAIL sw_regs got %0d %0d want 1 2", out_rs1, out_rs2); end
  endtask

  task automatic test_branch();
    send(32'hFE000EE3, 32'h108);
    checks++; if (flags !== F_BR) begin errors++; $display("FAIL beq_flags got %h want %h", flags, F_BR); end
    checks++; if (out_br_f3 !== 3'b000) begin errors++; $display("FAIL beq_f3 got %b want 000", out_br_f3); end
    checks++; if (out_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got %h want fffffffc", out_imm); end
  endtask

  task automatic test_mul();
    send(32'h022081B3, 32'h10C);
`ifdef RV32_DECODE_M_EN
    checks++; if (out_alu_op !== 5'd10) begin errors++; $display("FAIL mul_alu got %0d want 10", out_alu_op); end
    checks++; if (flags !== F_RW) begin errors++; $display("FAIL mul_flags got %h want %h", flags, F_RW); end
`else
    checks++; if (flags !== F_ILL) begin errors++; $display("FAIL mul_flags got %h want %h", flags, F_ILL); end
`endif
  endtask

  task automatic test_alu_variants();
    send(32'h407302B3, 32'h110);
    checks++; if (out_alu_op !== 5'd1 || flags !== F_RW) begin errors++; $display("FAIL sub got alu %0d flags %h want 1 %h", out_alu_op, flags, F_RW); end
    checks++; if (out_imm !== 32'h0) begin errors++; $display("FAIL sub_imm got %h want 0", out_imm); end
    send(32'h4030D093, 32'h114);
    checks++; if (out_alu_op !== 5'd7 || flags !== (F_RW | F_IMM)) begin errors++; $display("FAIL srai got alu %0d flags %h want 7 %h", out_alu_op, flags, F_RW | F_IMM); end
    send(32'h40309093, 32'h118);
    checks++; if ((flags & ~F_IMM) !== F_ILL) begin errors++; $display("FAIL bad_slli got flags %h want %h", flags & ~F_IMM, F_ILL); end
  endtask

  task automatic test_mem();
    send(32'h00812083, 32'h120);
    checks++; if (flags !== (F_RW | F_MR | F_IMM)) begin errors++; $display("FAIL lw_flags got %h want %h", flags, F_RW | F_MR | F_IMM); end
    checks++; if (out_imm !== 32'd8 || out_mem_f3 !== 3'b010 || out_alu_op !== 5'd0) begin errors++; $display("FAIL lw_fields got imm %h f3 %b alu %0d want 8 010 0", out_imm, out_mem_f3, out_alu_op); end
    send(32'h00013083, 32'h124);
    checks++; if ((flags & ~F_IMM) !== F_ILL) begin errors++; $display("FAIL ld_illegal got %h want %h", flags & ~F_IMM, F_ILL); end
  endtask

  task automatic test_control();
    send(32'h123452B7, 32'h130);
    checks++; if (flags !== (F_RW | F_LUI | F_IMM) || out_imm !== 32'h12345000) begin errors++; $display("FAIL lui got flags %h imm %h want %h 12345000", flags, out_imm, F_RW | F_LUI | F_IMM); end
    send(32'h00001297, 32'h134);
    checks++; if (flags !== (F_RW | F_AUIPC | F_IMM) || out_imm !== 32'h1000) begin errors++; $display("FAIL auipc got flags %h imm %h want %h 1000", flags, out_imm, F_RW | F_AUIPC | F_IMM); end
    send(32'h008000EF, 32'h138);
    checks++; if ((flags & ~F_IMM) !== (F_RW | F_JAL) || out_imm !== 32'd8) begin errors++; $display("FAIL jal got flags %h imm %h want %h 8", flags & ~F_IMM, out_imm, F_RW | F_JAL); end
    send(32'h0080006F, 32'h13C);
    checks++; if ((flags & ~F_IMM) !== F_JAL) begin errors++; $display("FAIL jal_x0 got flags %h want %h", flags & ~F_IMM, F_JAL); end
  endtask

  task automatic test_system();
    send(32'h00000073, 32'h140);
    checks++; if ((flags & ~F_IMM) !== F_SYS) begin errors++; $display("FAIL ecall got %h want %h", flags & ~F_IMM, F_SYS); end
    send(32'h00100073, 32'h144);
    checks++; if ((flags & ~F_IMM) !== F_SYS) begin errors++; $display("FAIL ebreak got %h want %h", flags & ~F_IMM, F_SYS); end
    send(32'h00200073, 32'h148);
    checks++; if ((flags & ~F_IMM) !== F_ILL) begin errors++; $display("FAIL sys_imm2 got %h want %h", flags & ~F_IMM, F_ILL); end
    send(32'h300110F3, 32'h14C);
    checks++; if ((flags & ~F_IMM) !== (F_SYS | F_RW)) begin errors++; $display("FAIL csrrw got %h want %h", flags & ~F_IMM, F_SYS | F_RW); end
    send(32'h0FF0000F, 32'h150);
    checks++; if ((flags & ~F_IMM) !== 11'h000) begin errors++; $display("FAIL fence got %h want 000", flags & ~F_IMM); end
    send(32'h00000000, 32'h154);
    checks++; if ((flags & ~F_IMM) !== F_ILL) begin errors++; $display("FAIL zero_word got %h want %h", flags & ~F_IMM, F_ILL); end
  endtask

  task automatic test_back_to_back();
    drain();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h200;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin errors++; $display("FAIL bp_first got valid %b pc %h want 1 200", out_valid, out_pc); end
    @(negedge clk);
    in_instr = 32'h407302B3; in_pc = 32'h204;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready stall %0d got %b want 0", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_pc !== 32'h200 || out_imm !== 32'hFFFFFFFF || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold stall %0d got pc %h imm %h valid %b", i, out_pc, out_imm, out_valid); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_pc !== 32'h204 || out_alu_op !== 5'd1) begin errors++; $display("FAIL bp_second got pc %h alu %0d want 204 1", out_pc, out_alu_op); end
    @(negedge clk);
    in_instr = 32'h123452B7; in_pc = 32'h208;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (outq.size() !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", outq.size()); end
    else if (outq[0] !== 32'h200 || outq[1] !== 32'h204 || outq[2] !== 32'h208) begin
      errors++; $display("FAIL bp_order got %h %h %h want 200 204 208", outq[0], outq[1], outq[2]);
    end
  endtask

  task automatic test_flush();
    drain();
    send(32'h00812083, 32'h300);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h407302B3; in_pc = 32'h304; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (out_pc !== 32'h300) begin errors++; $display("FAIL flush_nocapture got pc %h want 300", out_pc); end
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || outq.size() !== 0) begin errors++; $display("FAIL flush_emitted got valid %b count %0d want 0 0", out_valid, outq.size()); end
  endtask

  task automatic test_reset_midstream();
    drain();
    out_ready = 1'b0;
    send(32'hFFF00093, 32'h400);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h407302B3; in_pc = 32'h404; flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || flags !== 11'h000) begin errors++; $display("FAIL rst_mid got valid %b pc %h flags %h want 0 0 000", out_valid, out_pc, flags); end
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store();
    test_branch();
    test_mul();
    test_alu_variants();
    test_mem();
    test_control();
    test_system();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/rv32_decode_stage.md
# rv32_decode_stage

Registered RV32I instruction decode stage between fetch and execute. It accepts a fetched instruction word and PC over a valid/ready handshake, then cracks the word per the `rv32_isa` encodings: register addresses, sign-extended immediate, ALU operation and control flags. It presents the decoded bundle to execute one cycle later through an output register with backpressure and flush. Unsupported encodings are reported as illegal rather than dropped.

## Interface
- `PcWidth`, default 32, width of the PC carried alongside the instruction.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard the held instruction; sampled on the clock edge.
- `in_valid`  in  1  fetch presents `in_instr`/`in_pc`.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  PcWidth  PC of `in_instr`.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  execute accepts the bundle.
- `out_pc`  out  PcWidth  PC of the decoded instruction.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register addresses (`RegAddrWidth`).
- `out_imm`  out  32  sign-extended immediate, in I/S/B/U/J form per opcode; 0 for R-type.
- `out_alu_op`  out  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
- `out_use_imm`  out  1  ALU operand B is `out_imm`.
- `out_reg_write`  out  1  instruction writes `rd`; forced 0 when `rd` is 0.
- `out_mem_read`, `out_mem_write`  out  1 each  load / store.
- `out_mem_f3`  out  3  funct3 for load/store size and signedness.
- `out_branch`  out  1  conditional branch; `out_br_f3` (3) carries the condition.
- `out_jal`, `out_jalr`, `out_lui`, `out_auipc`, `out_system`  out  1 each  class flags.
- `out_illegal`  out  1  encoding not supported.

## Operation
- Combinational decode of `in_instr` is captured into the output register on handshake `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is a single-entry pipeline register, with no bubble when both sides flow.
- Opcodes handled: ALU-R, ALU-I, LOAD, STORE, BRANCH, JAL, JALR, LUI (0110111), AUIPC (0010111), MISC-MEM, SYSTEM.
- AUIPC is decoded as 0010111. The package constant `OpAUIPC` is corrected to this value as part of this block.
- LUI, AUIPC, JAL and JALR set `out_reg_write`. Loads and ALU ops also set it. Stores, branches, FENCE and SYSTEM do not.
- The ALU function is selected by funct3 and funct7.
  - funct7 0100000 selects SUB when funct3 is 000 and SRA when funct3 is 101.
  - ALU-I never produces SUB.
  - SRAI requires imm[11:5] to be 0100000. SLLI and SRLI require imm[11:5] to be 0000000.
- Loads, stores and JALR use ADD with `out_use_imm`=1. LUI and AUIPC set `out_use_imm`=1.
- FENCE and FENCE.I decode as no-op (`out_system`=0, no writes).
- SYSTEM: ECALL (imm 0) and EBREAK (imm 1) with funct3 000, and all CSR funct3 values, set `out_system`. CSR ops also set `out_reg_write`.
- The instruction is illegal when any of these hold:
  - `instr[1:0]` is not 11, or the opcode is unknown.
  - An ALU-R funct7 value is not listed above.
  - A shift-immediate has a bad imm[11:5].
  - A load has funct3 011, 110 or 111.
  - A store has funct3 above 010.
  - A branch has funct3 010 or 011.
  - JALR has a nonzero funct3.
  - A SYSTEM instruction has funct3 100, or funct3 000 with an imm other than 0 or 1.
- An illegal instruction is still delivered with `out_valid`=1 and `out_illegal`=1. Its reg_write, mem_read, mem_write, branch, jal, jalr and system flags are forced to 0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on the `out_*` ports after edge N.
- Throughput is 1 instruction per cycle while `out_ready` is held at 1.
- With `out_valid`=1 and `out_ready`=0, every output holds stable and `in_ready`=0.
- `flush`=1 at an edge clears `out_valid` and suppresses capture that cycle, even if `in_valid` is high.
  - `in_ready` is not gated by `flush`, so fetch must treat a flush-cycle transfer as discarded.
- Reset state:
  - `out_valid`=0, so `in_ready`=1 while `rst` is deasserted.
  - Every other registered output is 0.
- Reset asserted mid-stream drops the held instruction. `rst` has priority over `flush` and capture.
- Output payload is only updated on capture. While `out_valid`=0 it holds its last value and is don't-care.

## Configuration
- `RV32_DECODE_M_EN`: when defined, ALU-R with funct7 0000001 decodes to MUL…REMU (alu_op 10–17) per funct3.
- When undefined, every funct7 0000001 encoding is illegal, and alu_op values 10–17 are never produced.

## Test plan
- Reset then ADDI x1,x0,-1 (0xFFF00093) at PC 0x100:
  - `out_rd`=1, `out_rs1`=0, `out_imm`=0xFFFFFFFF, `out_alu_op`=0, `out_use_imm`=1, `out_reg_write`=1.
  - `out_pc`=0x100 one cycle later.
- SW x2,4(x1) (0x0020A223): `out_mem_write`=1, `out_mem_f3`=010, `out_imm`=4, `out_rs1`=1, `out_rs2`=2, `out_reg_write`=0.
- BEQ x0,x0,-4 (0xFE000EE3): `out_branch`=1, `out_br_f3`=000, `out_imm`=0xFFFFFFFC.
- MUL x3,x1,x2 (0x022081B3): with `RV32_DECODE_M_EN`, `out_alu_op`=10 and `out_reg_write`=1; without it, `out_illegal`=1 and `out_reg_write`=0.
- Backpressure: stream 3 back-to-back instructions with `out_ready`=0 for 2 cycles.
  - The first bundle holds stable and `in_ready`=0 while stalled.
  - All 3 emerge in order with none lost or duplicated.
- Assert `flush` with `in_valid`=1 while `out_valid`=1: next cycle `out_valid`=0 and the flushed-cycle instruction is not emitted. Also decode 0x00000000 → `out_illegal`=1.
